// File: rtl/mips_pkg.sv
// Shared fetch-path types and widths: PC/instruction sizes, fetch FSM states,
// and the prefetch buffer entry layout.
package mips_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ENTRY_W = PC_W + INSTR_W;

  localparam logic [PC_W-1:0] PC_INC = 16'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO with synchronous flush; the head entry is read
// combinationally so a push is visible on the very next cycle.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned       DEPTH     = 2,
  parameter int unsigned       WIDTH     = ENTRY_W,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             empty_c,
  output logic             full_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[PTR_W'(i)] <= RESET_VAL;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_c  = mem[rd_ptr];
  assign empty_c = (count == '0);
  assign full_c  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks pc through instruction memory, buffers
// fetched words in a prefetch FIFO and streams them out over valid/ready.
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_EN,
  input  logic               i_REDIRECT,
  input  logic [PC_W-1:0]    i_REDIRECT_PC,
  output logic [PC_W-1:0]    o_IMEM_A,
  input  logic [INSTR_W-1:0] i_IMEM_RD,
  output logic               o_VALID,
  input  logic               i_READY,
  output logic [INSTR_W-1:0] o_INSTR,
  output logic [PC_W-1:0]    o_PC,
  output logic               o_ERR
);

  fetch_state_e state;
  logic [PC_W-1:0] pc;
  logic            err;

  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         empty;
  logic         full;
  logic         push;
  logic         pop;
  logic         redir_ok;
  logic         redir_bad;
  logic         flush;

  // Redirects are ignored once halted; a misaligned target halts the fetcher.
  assign redir_ok  = i_REDIRECT && (state != HALT) && (i_REDIRECT_PC[1:0] == 2'b00);
  assign redir_bad = i_REDIRECT && (state != HALT) && (i_REDIRECT_PC[1:0] != 2'b00);
  assign flush     = redir_ok || redir_bad;

  assign o_VALID = !empty && (state != HALT);
  assign pop     = o_VALID && i_READY && !flush;
  assign push    = (state == FETCH) && (!full || pop) && !flush;

  assign push_entry.pc    = pc;
  assign push_entry.instr = i_IMEM_RD;

  fetch_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (ENTRY_W),
    .RESET_VAL ({RESET_PC, {INSTR_W{1'b0}}})
  ) u_fifo (
    .clk       (i_CLK),
    .rst_n     (i_RST_N),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_c    (head),
    .empty_c   (empty),
    .full_c    (full)
  );

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state <= IDLE;
      pc    <= RESET_PC;
      err   <= 1'b0;
    end else begin
      if (redir_bad) begin
        state <= HALT;
        err   <= 1'b1;
      end else begin
        case (state)
          IDLE:    if (i_EN)  state <= FETCH;
          FETCH:   if (!i_EN) state <= IDLE;
          default: state <= HALT;
        endcase
      end
      if (redir_ok) begin
        pc <= i_REDIRECT_PC;
      end else if (push) begin
        pc <= pc + PC_INC;
      end
    end
  end

  assign o_IMEM_A = pc;
  assign o_INSTR  = head.instr;
  assign o_PC     = head.pc;
  assign o_ERR    = err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: memory returns its own address, and an
// expected-PC queue is filled as stimulus is set up and drained on each accepted beat.
module tb_fetch_ctrl;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_a;
  logic [31:0] imem_rd;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [15:0] pc_out;
  logic        err;

  int n_checks;
  int n_fails;
  logic [15:0] exp_q[$];

  fetch_ctrl #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
    .i_CLK         (clk),
    .i_RST_N       (rst_n),
    .i_EN          (en),
    .i_REDIRECT    (redirect),
    .i_REDIRECT_PC (redirect_pc),
    .o_IMEM_A      (imem_a),
    .i_IMEM_RD     (imem_rd),
    .o_VALID       (valid),
    .i_READY       (ready),
    .o_INSTR       (instr),
    .o_PC          (pc_out),
    .o_ERR         (err)
  );

  assign imem_rd = {16'h0000, imem_a};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++;
    if (err !== 1'b0) begin n_fails++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++;
    if (pc_out !== 16'h0000) begin n_fails++; $display("FAIL reset_pc: got %h want 0000", pc_out); end
    n_checks++;
    if (instr !== 32'h0) begin n_fails++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_checks++;
    if (imem_a !== 16'h0000) begin n_fails++; $display("FAIL reset_imem_a: got %h want 0000", imem_a); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [15:0] e;
    do_reset();
    en = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(16'(4 * i));
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin n_fails++; $display("FAIL stream_latency: valid got %b want 0", valid); end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (valid !== 1'b1) begin n_fails++; $display("FAIL stream_valid[%0d]: got %b want 1", i, valid); end
      n_checks++;
      if (pc_out !== e) begin n_fails++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pc_out, e); end
      n_checks++;
      if (instr !== {16'h0000, e}) begin n_fails++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr, {16'h0000, e}); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [15:0] e;
    do_reset();
    en = 1'b1;
    ready = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(16'(4 * i));
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b1 || pc_out !== exp_q[0]) begin
        n_fails++; $display("FAIL stall_head[%0d]: got valid=%b pc=%h want valid=1 pc=%h", c, valid, pc_out, exp_q[0]);
      end
      if (c >= 1) begin
        n_checks++;
        if (imem_a !== 16'(4 * DEPTH)) begin n_fails++; $display("FAIL stall_imem_a[%0d]: got %h want %h", c, imem_a, 16'(4 * DEPTH)); end
      end
    end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (valid !== 1'b1 || pc_out !== e) begin
        n_fails++; $display("FAIL stall_drain[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, valid, pc_out, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    logic [15:0] e;
    do_reset();
    en = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin n_fails++; $display("FAIL redir_flush: valid got %b want 0", valid); end
    n_checks++;
    if (imem_a !== 16'h0100) begin n_fails++; $display("FAIL redir_imem_a: got %h want 0100", imem_a); end
    ready = 1'b1;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0104);
    exp_q.push_back(16'h0108);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (valid !== 1'b1 || pc_out !== e) begin
        n_fails++; $display("FAIL redir_seq[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, valid, pc_out, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    do_reset();
    en = 1'b1;
    ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'hFFF8;
    exp_q.push_back(16'hFFF8);
    exp_q.push_back(16'hFFFC);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0004);
    @(negedge clk);
    redirect = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || imem_a !== 16'hFFF8) begin
      n_fails++; $display("FAIL wrap_start: got valid=%b imem_a=%h want valid=0 imem_a=fff8", valid, imem_a);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (valid !== 1'b1 || pc_out !== e || instr !== {16'h0000, e}) begin
        n_fails++; $display("FAIL wrap_seq[%0d]: got valid=%b pc=%h instr=%h want pc=%h", i, valid, pc_out, instr, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idle();
    logic [15:0] e;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++;
    if (imem_a !== 16'h0040 || valid !== 1'b0) begin
      n_fails++; $display("FAIL idle_redir: got imem_a=%h valid=%b want 0040 0", imem_a, valid);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (imem_a !== 16'h0040 || valid !== 1'b0) begin
      n_fails++; $display("FAIL idle_hold: got imem_a=%h valid=%b want 0040 0", imem_a, valid);
    end
    en = 1'b1;
    exp_q.push_back(16'h0040);
    exp_q.push_back(16'h0044);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (valid !== 1'b1 || pc_out !== e) begin
        n_fails++; $display("FAIL idle_pop[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, valid, pc_out, e);
      end
      @(negedge clk);
    end
    n_checks++;
    if (valid !== 1'b0 || imem_a !== 16'h0048) begin
      n_fails++; $display("FAIL idle_empty: got valid=%b imem_a=%h want 0 0048", valid, imem_a);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    en = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'h0102;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin n_fails++; $display("FAIL misalign_err: got %b want 1", err); end
    n_checks++;
    if (valid !== 1'b0) begin n_fails++; $display("FAIL misalign_valid: got %b want 0", valid); end
    n_checks++;
    if (imem_a !== 16'h0008) begin n_fails++; $display("FAIL misalign_pc_hold: got %h want 0008", imem_a); end
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b0 || err !== 1'b1 || imem_a !== 16'h0008) begin
        n_fails++; $display("FAIL halt_ignore[%0d]: got valid=%b err=%b imem_a=%h want 0 1 0008", i, valid, err, imem_a);
      end
    end
    redirect = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b0) begin n_fails++; $display("FAIL halt_reset_err: got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    ready = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (valid !== 1'b1) begin n_fails++; $display("FAIL areset_pre: valid got %b want 1", valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid !== 1'b0 || pc_out !== 16'h0000 || imem_a !== 16'h0000) begin
      n_fails++; $display("FAIL areset_now: got valid=%b pc=%h imem_a=%h want 0 0000 0000", valid, pc_out, imem_a);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) begin n_fails++; $display("FAIL areset_idle: valid got %b want 0", valid); end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || pc_out !== 16'h0000) begin
      n_fails++; $display("FAIL areset_first: got valid=%b pc=%h want 1 0000", valid, pc_out);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    en = 1'b0;
    ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    n_checks = 0;
    n_fails = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_idle();
    test_misaligned();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
